sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 84 ++++++++
 tb/tb_sync_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and status; SYNC_FIFO_STICKY_ERR_EN makes overflow/underflow sticky.
// Latency: data_out, wr_ack, overflow and underflow are registered one edge after the request; flags follow count combinationally.
// Backpressure: a write while full or a read while empty is dropped and reported; the other side of a simultaneous request proceeds.
module sync_fifo #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  almostfull,
   output logic                  empty,
   output logic                  almostempty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] LAST_PTR  = AW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ONE_CNT   = CW'(1);

   logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  wr_ok;
   logic                  rd_ok;

   assign wr_ok = wr_en && (count != DEPTH_CNT);
   assign rd_ok = rd_en && (count != '0);

   assign full        = (count == DEPTH_CNT);
   assign almostfull  = (count == DEPTH_CNT - ONE_CNT);
   assign empty       = (count == '0);
   assign almostempty = (count == ONE_CNT);

   // Storage is deliberately not reset; count=0 keeps stale words unreachable.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         data_out  <= '0;
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         wr_ack <= wr_ok;
         if (wr_ok) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + ONE_CNT;
            2'b01:   count <= count - ONE_CNT;
            default: count <= count;
         endcase
`ifdef SYNC_FIFO_STICKY_ERR_EN
         overflow  <= overflow  | (wr_en && !wr_ok);
         underflow <= underflow | (rd_en && !rd_ok);
`else
         overflow  <= wr_en && !wr_ok;
         underflow <= rd_en && !rd_ok;
`endif
      end
   end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a depth-8 instance for fill/drain/error/reset cases and a depth-6 instance for pointer wrap.
module tb_sync_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data_in, data_in6;
   logic        wr_en, rd_en, wr_en6, rd_en6;
   logic [15:0] data_out, data_out6;
   logic        wr_ack, overflow, underflow, full, almostfull, empty, almostempty;
   logic        wr_ack6, overflow6, underflow6, full6, almostfull6, empty6, almostempty6;

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] model_q[$];
   logic [15:0] exp_word;
   logic [15:0] next_word;

   always #5 clk = ~clk;

   sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) u_dut (
      .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
      .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
      .full(full), .almostfull(almostfull), .empty(empty), .almostempty(almostempty)
   );

   sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(6)) u_dut6 (
      .clk(clk), .rst(rst), .data_in(data_in6), .wr_en(wr_en6), .rd_en(rd_en6),
      .data_out(data_out6), .wr_ack(wr_ack6), .overflow(overflow6), .underflow(underflow6),
      .full(full6), .almostfull(almostfull6), .empty(empty6), .almostempty(almostempty6)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h0055;
      wr_en6 = 1'b0; rd_en6 = 1'b0; data_in6 = '0;
      tick();
      tick();
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_almostfull", almostfull, 0);
      check("rst_almostempty", almostempty, 0);
      check("rst_data_out", data_out, 0);
      check("rst_wr_ack", wr_ack, 0);
      check("rst_overflow", overflow, 0);
      check("rst_underflow", underflow, 0);
      check("rst_empty6", empty6, 1);

      // Fill with 0x0001..0x0008
      for (int i = 1; i <= 8; i++) begin
         wr_en = 1'b1; data_in = 16'(i);
         tick();
         check($sformatf("fill_wr_ack_%0d", i), wr_ack, 1);
         check($sformatf("fill_almostfull_%0d", i), almostfull, (i == 7) ? 1 : 0);
         check($sformatf("fill_full_%0d", i), full, (i == 8) ? 1 : 0);
         if (i == 1) check("fill_almostempty_1", almostempty, 1);
      end

      // Write while full is rejected
      data_in = 16'hDEAD;
      tick();
      wr_en = 1'b0;
      check("ovf_wr_ack", wr_ack, 0);
      check("ovf_overflow", overflow, 1);
      check("ovf_full", full, 1);
      tick();
`ifdef SYNC_FIFO_STICKY_ERR_EN
      check("ovf_sticky", overflow, 1);
`else
      check("ovf_pulse", overflow, 0);
`endif

      // Drain in order
      for (int i = 1; i <= 8; i++) begin
         if (i == 8) check("drain_almostempty_before_last", almostempty, 1);
         rd_en = 1'b1;
         tick();
         check($sformatf("drain_data_%0d", i), data_out, 16'(i));
      end
      rd_en = 1'b0;
      check("drain_empty", empty, 1);
      tick();
      check("drain_hold", data_out, 16'h0008);

      // Simultaneous write/read on empty: write only
      wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h00AA;
      tick();
      wr_en = 1'b0; rd_en = 1'b1;
      check("emp_both_almostempty", almostempty, 1);
      check("emp_both_underflow", underflow, 1);
      check("emp_both_data_hold", data_out, 16'h0008);
      check("emp_both_wr_ack", wr_ack, 1);
      tick();
      rd_en = 1'b0;
      check("emp_both_readback", data_out, 16'h00AA);
      check("emp_both_empty_after", empty, 1);
`ifndef SYNC_FIFO_STICKY_ERR_EN
      check("emp_both_underflow_clear", underflow, 0);
`endif

      // Depth 6: prefill 5, then alternate write/read across the wrap
      next_word = 16'h0100;
      for (int i = 0; i < 5; i++) begin
         wr_en6 = 1'b1; data_in6 = next_word;
         model_q.push_back(next_word); next_word++;
         tick();
      end
      wr_en6 = 1'b0;
      check("d6_prefill_almostfull", almostfull6, 1);
      for (int k = 0; k < 20; k++) begin
         if (k % 2 == 0) begin
            wr_en6 = 1'b1; rd_en6 = 1'b0; data_in6 = next_word;
            model_q.push_back(next_word); next_word++;
            tick();
            check($sformatf("d6_full_%0d", k), full6, 1);
            check($sformatf("d6_wr_ack_%0d", k), wr_ack6, 1);
         end else begin
            wr_en6 = 1'b0; rd_en6 = 1'b1;
            exp_word = model_q.pop_front();
            tick();
            check($sformatf("d6_data_%0d", k), data_out6, exp_word);
            check($sformatf("d6_almostfull_%0d", k), almostfull6, 1);
         end
      end
      // Extra write at full must not push count beyond 6
      wr_en6 = 1'b1; rd_en6 = 1'b0; data_in6 = 16'hBEEF;
      tick();
      check("d6_wr_ack_after_alt", wr_ack6, 1);
      wr_en6 = 1'b1; data_in6 = 16'hDEAD;
      model_q.push_back(16'hBEEF);
      tick();
      check("d6_overflow", overflow6, 1);
      check("d6_still_full", full6, 1);
      // Simultaneous write/read in the middle keeps count
      wr_en6 = 1'b0; rd_en6 = 1'b1;
      exp_word = model_q.pop_front();
      tick();
      check("d6_read_from_full", data_out6, exp_word);
      wr_en6 = 1'b1; rd_en6 = 1'b1; data_in6 = 16'h0CAF;
      model_q.push_back(16'h0CAF);
      exp_word = model_q.pop_front();
      tick();
      check("d6_both_data", data_out6, exp_word);
      check("d6_both_count_kept", almostfull6, 1);
      wr_en6 = 1'b0; rd_en6 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_word = model_q.pop_front();
         tick();
         check($sformatf("d6_drain_%0d", i), data_out6, exp_word);
      end
      rd_en6 = 1'b0;
      check("d6_drain_empty", empty6, 1);

      // Reset mid-stream with count=5 and a write pending
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; data_in = 16'h0010 + 16'(i);
         tick();
      end
      check("mid_count5_not_empty", empty, 0);
      rst = 1'b1; wr_en = 1'b1; data_in = 16'h0077;
      tick();
      rst = 1'b0; wr_en = 1'b0;
      check("mid_rst_empty", empty, 1);
      check("mid_rst_almostempty", almostempty, 0);
      check("mid_rst_data_out", data_out, 0);
      check("mid_rst_wr_ack", wr_ack, 0);
      check("mid_rst_overflow", overflow, 0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("mid_rst_stale_underflow", underflow, 1);
      check("mid_rst_stale_data", data_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
